// File: rtl/interp_mult_bank.sv
// Interpolation multiple bank: slot k of mult_bus receives (k+1)*E, one slot per cycle.
// Define INTERP_MULT_SAT_EN to clamp out-of-range multiples; otherwise they wrap to OUT_W bits.
module interp_mult_bank #(
  parameter int IN_W     = 16,
  parameter int OUT_W    = 20,
  parameter int NUM_MULT = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [IN_W-1:0]           in_e,
  input  logic                      clear,
  output logic [NUM_MULT*OUT_W-1:0] mult_bus,
  output logic [NUM_MULT-1:0]       mult_vld,
  output logic                      busy,
  output logic                      done
);

  localparam int ACC_W = IN_W + $clog2(NUM_MULT) + 1;
  localparam int EXT_W = (ACC_W > OUT_W) ? ACC_W : OUT_W;
  // idx counts one past the last slot so the final write gets its own ACCUM cycle
  localparam int IDX_W = $clog2(NUM_MULT + 1);
  localparam logic [IDX_W-1:0] IDX_END = IDX_W'(NUM_MULT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                   state_r;
  state_t                   state_s;
  logic signed [IN_W-1:0]   e_r;
  logic signed [ACC_W-1:0]  acc_r;
  logic signed [ACC_W-1:0]  acc_s;
  logic signed [ACC_W-1:0]  e_in_s;
  logic [IDX_W-1:0]         idx_r;
  logic [OUT_W-1:0]         slot_r [NUM_MULT];
  logic [NUM_MULT-1:0]      vld_r;
  logic                     ready_r;
  logic                     busy_r;
  logic                     done_r;
  logic                     fire_s;
  logic                     last_s;

  // Narrow an accumulator value to the stored slot width.
  function automatic logic [OUT_W-1:0] narrow(input logic signed [ACC_W-1:0] v);
`ifdef INTERP_MULT_SAT_EN
    logic signed [EXT_W-1:0] x;
    logic signed [EXT_W-1:0] hi;
    logic signed [EXT_W-1:0] lo;
    x  = EXT_W'(v);
    hi = '0;
    hi[OUT_W-2:0] = '1;
    lo = '1;
    lo[OUT_W-2:0] = '0;
    if (x > hi) begin
      narrow = hi[OUT_W-1:0];
    end else if (x < lo) begin
      narrow = lo[OUT_W-1:0];
    end else begin
      narrow = x[OUT_W-1:0];
    end
`else
    narrow = OUT_W'(v);
`endif
  endfunction

  // Handshake, end-of-run detect and next accumulator value.
  always_comb begin
    fire_s = in_valid && ready_r && (state_r == IDLE);
    last_s = (idx_r == IDX_END);
    e_in_s = ACC_W'($signed(in_e));
    acc_s  = acc_r + ACC_W'(e_r);
  end

  // Next-state logic; clear overrides everything.
  always_comb begin
    state_s = state_r;
    if (clear) begin
      state_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (fire_s) begin
            state_s = (NUM_MULT == 1) ? DONE : ACCUM;
          end else begin
            state_s = IDLE;
          end
        end
        ACCUM: begin
          if (last_s) begin
            state_s = DONE;
          end else begin
            state_s = ACCUM;
          end
        end
        DONE:    state_s = IDLE;
        default: state_s = IDLE;
      endcase
    end
  end

  // State register and registered status outputs decoded from the next state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
      ready_r <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      ready_r <= (state_s == IDLE);
      busy_r  <= (state_s != IDLE);
      done_r  <= (state_s == DONE);
    end
  end

  // Datapath: latch E, accumulate and store one multiple per cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      e_r   <= '0;
      acc_r <= '0;
      idx_r <= '0;
      vld_r <= '0;
      for (int k = 0; k < NUM_MULT; k++) begin
        slot_r[k] <= '0;
      end
    end else if (clear) begin
      e_r   <= '0;
      acc_r <= '0;
      idx_r <= '0;
      vld_r <= '0;
      for (int k = 0; k < NUM_MULT; k++) begin
        slot_r[k] <= '0;
      end
    end else if (fire_s) begin
      e_r       <= $signed(in_e);
      acc_r     <= e_in_s;
      idx_r     <= IDX_W'(1);
      vld_r     <= '0;
      vld_r[0]  <= 1'b1;
      slot_r[0] <= narrow(e_in_s);
    end else if ((state_r == ACCUM) && !last_s) begin
      acc_r <= acc_s;
      idx_r <= idx_r + IDX_W'(1);
      for (int k = 0; k < NUM_MULT; k++) begin
        if (idx_r == IDX_W'(k)) begin
          slot_r[k] <= narrow(acc_s);
          vld_r[k]  <= 1'b1;
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_MULT; g++) begin : g_bus
    assign mult_bus[g*OUT_W +: OUT_W] = slot_r[g];
  end

  assign in_ready = ready_r;
  assign mult_vld = vld_r;
  assign busy     = busy_r;
  assign done     = done_r;

endmodule

// File: tb/tb_interp_mult_bank.sv
// Scoreboard bench for interp_mult_bank: default instance (A) plus a narrow OUT_W=17,
// NUM_MULT=3 instance (B) that exercises wrap or saturation.
module tb_interp_mult_bank;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid_a = 1'b0, clear_a = 1'b0, in_ready_a, busy_a, done_a;
  logic [15:0] in_e_a = '0;
  logic [99:0] bus_a;
  logic [4:0]  vld_a;
  logic        in_valid_b = 1'b0, clear_b = 1'b0, in_ready_b, busy_b, done_b;
  logic [15:0] in_e_b = '0;
  logic [50:0] bus_b;
  logic [2:0]  vld_b;

  int checks = 0;
  int failures = 0;
  logic [159:0] qa[$];
  logic [159:0] qb[$];

  interp_mult_bank dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid_a), .in_ready(in_ready_a), .in_e(in_e_a),
    .clear(clear_a), .mult_bus(bus_a), .mult_vld(vld_a), .busy(busy_a), .done(done_a));

  interp_mult_bank #(.IN_W(16), .OUT_W(17), .NUM_MULT(3)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_ready(in_ready_b), .in_e(in_e_b),
    .clear(clear_b), .mult_bus(bus_b), .mult_vld(vld_b), .busy(busy_b), .done(done_b));

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: (k+1)*E, then clamp or wrap into an ow-bit signed range.
  function automatic int model_slot(input int e, input int k, input int ow);
    longint m, lim;
    m   = longint'(k + 1) * longint'(e);
    lim = longint'(1) <<< (ow - 1);
`ifdef INTERP_MULT_SAT_EN
    if (m > lim - 1) m = lim - 1;
    else if (m < -lim) m = -lim;
    return int'(m);
`else
    begin
      longint span, w;
      span = lim * 2;
      w = m % span;
      if (w < 0) w += span;
      if (w >= lim) w -= span;
      return int'(w);
    end
`endif
  endfunction

  function automatic longint dut_slot(input logic [99:0] bus, input int k, input int ow);
    logic [99:0] t, mask;
    longint r, lim;
    mask = (100'd1 << ow) - 100'd1;
    t    = (bus >> (k * ow)) & mask;
    r    = longint'(t[63:0]);
    lim  = longint'(1) <<< (ow - 1);
    if (r >= lim) r -= 2 * lim;
    return r;
  endfunction

  function automatic logic rdy(input bit sel); return sel ? in_ready_b : in_ready_a; endfunction
  function automatic logic dn(input bit sel);  return sel ? done_b : done_a;         endfunction
  function automatic logic bsy(input bit sel); return sel ? busy_b : busy_a;         endfunction
  function automatic int vld(input bit sel);   return sel ? int'(vld_b) : int'(vld_a); endfunction
  function automatic logic [99:0] bus(input bit sel); return sel ? 100'(bus_b) : bus_a; endfunction

  task automatic set_in(input bit sel, input logic v, input int e);
    if (sel) begin in_valid_b = v; in_e_b = 16'(e); end
    else     begin in_valid_a = v; in_e_a = 16'(e); end
  endtask

  task automatic set_clr(input bit sel, input logic v);
    if (sel) clear_b = v; else clear_a = v;
  endtask

  task automatic check_done(input bit sel);
    logic [159:0] ex;
    int nm, ow;
    nm = sel ? 3 : 5;
    ow = sel ? 17 : 20;
    if ((sel ? qb.size() : qa.size()) == 0) begin
      chk(sel ? "unexpected_done_b" : "unexpected_done_a", 1, 0);
      return;
    end
    ex = sel ? qb.pop_front() : qa.pop_front();
    for (int k = 0; k < nm; k++)
      chk($sformatf("slot%0d_%s", k, sel ? "b" : "a"), dut_slot(bus(sel), k, ow),
          longint'($signed(ex[k*32 +: 32])));
    chk(sel ? "vld_full_b" : "vld_full_a", vld(sel), (1 << nm) - 1);
  endtask

  // Monitor: every done pulse is matched against the oldest expected result.
  always @(negedge clk) begin
    if (rst && done_a) check_done(1'b0);
    if (rst && done_b) check_done(1'b1);
  end

  // mode 0: plain, 1: noisy in_valid during ACCUM, 2: clear mid-run, 3: reset mid-run
  task automatic run_op(input bit sel, input int e, input int mode);
    int cnt, nm, ow, bits;
    logic [159:0] ex;
    nm = sel ? 3 : 5;
    ow = sel ? 17 : 20;
    cnt = 0;
    while (!rdy(sel) && cnt < 50) begin @(negedge clk); cnt++; end
    if (!rdy(sel)) begin chk("ready_timeout", 0, 1); return; end
    set_in(sel, 1'b1, e);
    @(posedge clk);
    if (mode < 2) begin
      ex = '0;
      for (int k = 0; k < nm; k++) ex[k*32 +: 32] = 32'(model_slot(e, k, ow));
      if (sel) qb.push_back(ex); else qa.push_back(ex);
    end
    @(negedge clk);
    if (mode == 1) set_in(sel, 1'b1, int'($urandom)); else set_in(sel, 1'b0, 0);
    if (mode == 2) begin
      chk("vld_first", vld(sel), 1);
      @(negedge clk);
      set_clr(sel, 1'b1);
      @(negedge clk);
      set_clr(sel, 1'b0);
      chk("clear_bus", longint'(|bus(sel)), 0);
      chk("clear_vld", vld(sel), 0);
      chk("clear_ready", rdy(sel), 1);
      chk("clear_busy", bsy(sel), 0);
      cnt = 0;
      repeat (10) begin @(negedge clk); if (dn(sel)) cnt++; end
      chk("no_done_after_clear", cnt, 0);
      return;
    end
    if (mode == 3) begin
      @(negedge clk);
      @(posedge clk);
      #2 rst = 1'b0;
      #1;
      chk("rst_bus", longint'(|bus(sel)), 0);
      chk("rst_vld", vld(sel), 0);
      chk("rst_busy", bsy(sel), 0);
      chk("rst_done", dn(sel), 0);
      chk("rst_ready_low", rdy(sel), 0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("ready_after_release", rdy(sel), 1);
      cnt = 0;
      repeat (8) begin @(negedge clk); if (dn(sel)) cnt++; end
      chk("no_done_after_rst", cnt, 0);
      return;
    end
    cnt = 0;
    while (!dn(sel) && cnt < 20) begin
      bits = (cnt + 1 < nm) ? cnt + 1 : nm;
      chk("vld_fill", vld(sel), (1 << bits) - 1);
      chk("ready_low_busy", rdy(sel), 0);
      chk("busy_high", bsy(sel), 1);
      if (mode == 1 && cnt == nm - 2) set_in(sel, 1'b0, 0);
      @(negedge clk);
      cnt++;
    end
    chk("done_latency", cnt, nm);
    @(negedge clk);
    chk("done_one_cycle", dn(sel), 0);
    chk("ready_after_done", rdy(sel), 1);
  endtask

  function automatic int rnd_e();
    logic [15:0] r;
    r = 16'($urandom);
    return int'($signed(r));
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_ready", in_ready_a, 0);
    chk("reset_busy", busy_a, 0);
    chk("reset_done", done_a, 0);
    chk("reset_bus", longint'(|bus_a), 0);
    chk("reset_vld", vld_a, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("ready_release_a", in_ready_a, 1);
    chk("ready_release_b", in_ready_b, 1);

    run_op(1'b0, 1000, 0);
    for (int k = 0; k < 5; k++) chk("hold_1000", dut_slot(bus_a, k, 20), 1000 * (k + 1));
    run_op(1'b0, -32768, 0);
    chk("slot4_neg", dut_slot(bus_a, 4, 20), -163840);
    run_op(1'b0, 7, 0);
    run_op(1'b0, 32767, 1);
    run_op(1'b0, 1234, 2);
    run_op(1'b0, 555, 3);
    for (int i = 0; i < 12; i++) run_op(1'b0, rnd_e(), int'($urandom_range(0, 1)));

    run_op(1'b1, 30000, 0);
    chk("b_slot1", dut_slot(bus(1'b1), 1, 17), 60000);
`ifdef INTERP_MULT_SAT_EN
    chk("b_slot2_sat", dut_slot(bus(1'b1), 2, 17), 65535);
`else
    chk("b_slot2_wrap", dut_slot(bus(1'b1), 2, 17), -41072);
`endif
    run_op(1'b1, -32768, 0);
    for (int i = 0; i < 8; i++) run_op(1'b1, rnd_e(), 0);

    repeat (3) @(negedge clk);
    chk("queue_a_empty", qa.size(), 0);
    chk("queue_b_empty", qb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
